// File: rtl/seq_serializer_pkg.sv
// seq_serializer_pkg: shared state encoding and sizing helper for the serializer
package seq_serializer_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/seq_bit_timer.sv
// seq_bit_timer: per-bit hold counter, ticks in the final cycle of each bit period
module seq_bit_timer
  import seq_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);
  localparam int CW = clog2(BIT_CYCLES);
  localparam logic [CW-1:0] TOP = CW'(BIT_CYCLES - 1);
  logic [CW-1:0] cyc_cnt;
  assign tick = run && (cyc_cnt == TOP);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cyc_cnt <= '0;
    else cyc_cnt <= (restart || tick || !run) ? '0 : cyc_cnt + CW'(1);
endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: MSB-first parallel-to-serial stage with gapless back-to-back loads
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter int         BIT_CYCLES = 2,
  parameter logic       IDLE_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    load,
  output logic                    ready,
  output logic                    seq,
  output logic                    busy,
  output logic                    done,
  output logic [clog2(WIDTH)-1:0] bit_idx
);
  localparam int BW = clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  state_t state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0] bit_cnt;
  logic tick, last, accept;
  assign last = tick && (bit_cnt == LAST_BIT);
  assign ready = (state == IDLE) || last;
  assign accept = load && ready;
  assign bit_idx = bit_cnt;
  seq_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .run(state == SHIFT),
    .restart(accept),
    .tick(tick)
  );
  // accept wins over end-of-word so a load in the last cycle continues without a gap bit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      seq     <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        state   <= SHIFT;
        sreg    <= data_in;
        bit_cnt <= '0;
        seq     <= data_in[WIDTH-1];
        busy    <= 1'b1;
      end else if (last) begin
        state   <= IDLE;
        sreg    <= '0;
        bit_cnt <= '0;
        seq     <= IDLE_LEVEL;
        busy    <= 1'b0;
      end else if (tick) begin
        sreg    <= {sreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + BW'(1);
        seq     <= sreg[WIDTH-2];
      end
    end
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed self-checking bench for seq_serializer
module tb_seq_serializer;
  logic clk = 1'b1;
  logic reset = 1'b0;
  logic load = 1'b1;
  logic [31:0] data_in = 32'hFFFF_FFFF;
  logic load2 = 1'b0;
  logic [3:0] data2 = 4'h0;
  logic ready, seq, busy, done;
  logic [4:0] bit_idx;
  logic ready2, seq2, busy2, done2;
  logic [1:0] bit_idx2;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  seq_serializer #(.WIDTH(32), .BIT_CYCLES(2), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .ready(ready),
    .seq(seq), .busy(busy), .done(done), .bit_idx(bit_idx)
  );
  seq_serializer #(.WIDTH(4), .BIT_CYCLES(1), .IDLE_LEVEL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .data_in(data2), .load(load2), .ready(ready2),
    .seq(seq2), .busy(busy2), .done(done2), .bit_idx(bit_idx2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic word32(input logic [31:0] w, input bit b2b, input int pulse_at);
    for (int n = 0; n < 64; n++) begin
      check($sformatf("seq n=%0d", n), seq, w[31-n/2]);
      check($sformatf("bit_idx n=%0d", n), bit_idx, n / 2);
      check($sformatf("busy n=%0d", n), busy, 1);
      check($sformatf("ready n=%0d", n), ready, n == 63);
      check($sformatf("done n=%0d", n), done, b2b && n == 0);
      if (pulse_at >= 0) begin
        load = (n == pulse_at);
        if (n == pulse_at) data_in = 32'h0;
      end
      if (n < 63) step();
    end
  endtask
  task automatic end_word();
    step();
    check("end done", done, 1);
    check("end busy", busy, 0);
    check("end seq", seq, 0);
    check("end ready", ready, 1);
    check("end bit_idx", bit_idx, 0);
    step();
    check("post done", done, 0);
    check("post busy", busy, 0);
    check("post seq", seq, 0);
  endtask
  task automatic accept(input logic [31:0] w);
    load = 1'b1;
    data_in = w;
    step();
    load = 1'b0;
  endtask
  initial begin
    logic [3:0] m;
    for (int t = 0; t < 3; t++) begin
      #(t == 0 ? 1 : 11);
      check("rst seq", seq, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst ready", ready, 1);
      check("rst bit_idx", bit_idx, 0);
    end
    #1;
    reset = 1'b1;
    load = 1'b0;
    step();
    check("no accept busy", busy, 0);
    check("no accept seq", seq, 0);
    // single word
    accept(32'b0110_0100_1000_0100_1010_1011_0001_0100);
    word32(32'h6484_AB14, 1'b0, -1);
    end_word();
    // back-to-back: load stays high, second word taken in last cycle only
    load = 1'b1;
    data_in = 32'h6484_AB14;
    step();
    data_in = 32'hA5A5_A5A5;
    word32(32'h6484_AB14, 1'b0, -1);
    step();
    load = 1'b0;
    word32(32'hA5A5_A5A5, 1'b1, -1);
    end_word();
    // load while busy must be ignored
    accept(32'hDEAD_BEEF);
    word32(32'hDEAD_BEEF, 1'b0, 10);
    end_word();
    check("ignored word busy", busy, 0);
    // reset mid-word
    accept(32'h6484_AB14);
    for (int n = 0; n < 20; n++) step();
    check("pre-abort bit_idx", bit_idx, 10);
    check("pre-abort busy", busy, 1);
    #3 reset = 1'b0;
    #1;
    check("abort seq", seq, 0);
    check("abort busy", busy, 0);
    check("abort bit_idx", bit_idx, 0);
    check("abort done", done, 0);
    check("abort ready", ready, 1);
    step();
    check("abort hold done", done, 0);
    #2 reset = 1'b1;
    step();
    check("abort after busy", busy, 0);
    check("abort after done", done, 0);
    accept(32'h8000_0001);
    word32(32'h8000_0001, 1'b0, -1);
    end_word();
    // minimal WIDTH=4, BIT_CYCLES=1
    m = 4'b1011;
    load2 = 1'b1;
    data2 = m;
    step();
    load2 = 1'b0;
    data2 = 4'h0;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("min seq n=%0d", n), seq2, m[3-n]);
      check($sformatf("min bit_idx n=%0d", n), bit_idx2, n);
      check($sformatf("min busy n=%0d", n), busy2, 1);
      check($sformatf("min done n=%0d", n), done2, 0);
      check($sformatf("min ready n=%0d", n), ready2, n == 3);
      step();
    end
    check("min end done", done2, 1);
    check("min end busy", busy2, 0);
    check("min end seq", seq2, 0);
    step();
    check("min post done", done2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
